alu_cmd_issue: RTL and testbench
================================

# alu_cmd_issue

Command-issue stage sitting directly upstream of the 8-bit combinational `alu`. It accepts `{sel, a, b}` commands over a valid/ready handshake and buffers them in a small FIFO. It drives the head command onto the ALU inputs, registers the ALU result, and presents it downstream over a second valid/ready handshake. Commands retire strictly in order, with a fixed minimum latency.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `WIDTH`, default 8: operand/result width; must match the ALU.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: upstream command valid.
- `cmd_ready` output 1: FIFO can accept; equals `!full`.
- `cmd_sel` input 3: ALU opcode.
- `cmd_a` input WIDTH: operand A.
- `cmd_b` input WIDTH: operand B.
- `alu_sel` output 3: to ALU `sel`.
- `alu_a` output WIDTH: to ALU `a`.
- `alu_b` output WIDTH: to ALU `b`.
- `alu_result` input WIDTH: from ALU `result`, combinational.
- `rsp_valid` output 1: result register holds a result.
- `rsp_ready` input 1: downstream accepts.
- `rsp_result` output WIDTH: registered ALU result.
- `rsp_sel` output 3: opcode that produced `rsp_result`.
- `fifo_count` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Push: `cmd_valid && cmd_ready` writes the entry at the tail.
- `alu_*` are driven from the FIFO head whenever the FIFO is non-empty. They are all-zero when the FIFO is empty.
- FSM states:
  - `IDLE`: FIFO empty and no response pending.
  - `EXEC`: head present and response slot free or draining this cycle.
  - `STALL`: `rsp_valid && !rsp_ready` with head present.
- Transitions:
  - `IDLE`→`EXEC` on the first push.
  - `EXEC`→`STALL` when the response is not taken.
  - `STALL`→`EXEC` on `rsp_ready`.
  - Any state→`IDLE` when the FIFO empties and the response drains.
- Pop/capture: in `EXEC`, capture `alu_result`/`alu_sel` into `rsp_*`, set `rsp_valid`, and pop the head. This happens in the same edge.
- Capture condition: `!empty && (!rsp_valid || rsp_ready)`. Back-to-back results sustain 1 per cycle.
- Simultaneous push and pop: occupancy is unchanged. Push while full is not possible, because `cmd_ready`=0 and ready never depends combinationally on a pop.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty are derived from `fifo_count`.
- No arithmetic is performed here. Widths pass through unchanged.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_sel`=0.
  - `fifo_count`=0.
  - `alu_*`=0.
  - State `IDLE`.
- Latency:
  - Command accepted at edge N appears on `alu_*` after N.
  - It is captured at N+1.
  - `rsp_valid` is high from N+1 until the response is taken.
- `rsp_*` are held stable while `rsp_valid && !rsp_ready`.
- Reset asserted mid-operation flushes the FIFO and the response register on that edge. In-flight commands are dropped.

## Configuration
- `ALU_CMD_ISSUE_ZERO_FLAG_EN`:
  - When defined, adds output `rsp_zero` (1 bit), equal to `rsp_result == 0`. It is registered alongside `rsp_result` and reset to 0.
  - When undefined, the port and register are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `ALU_ADD`=0, `ALU_SUB`=1, `ALU_AND`=2, `ALU_OR`=3, `ALU_XOR`=4, `ALU_SHL`=5, `ALU_SHR`=6, `ALU_PASSA`=7.
  - Command struct/typedef `{sel, a, b}`.
  - FSM state enum.
- One sub-module: `alu_cmd_fifo`. It is a parameterised sync FIFO with count, full and empty, instantiated once.

## Test plan
- Reset sequencing:
  - Stimulus: reset, then a=15, b=3, sel=0..7 pushed back-to-back, `rsp_ready`=1.
  - Response: `rsp_result` = 18, 12, 3, 15, 12, 30, 7, 15 on consecutive cycles.
  - First `rsp_valid` is one cycle after the first push.
- Backpressure:
  - Stimulus: `rsp_ready`=0, push 5 commands with DEPTH=4.
  - Response: 4 accepted plus 1 captured. `cmd_ready`=0, `fifo_count`=4, `rsp_*` stable.
  - Releasing `rsp_ready` drains all 5 in order.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, then assert `rsp_ready` and `cmd_valid`.
  - Response: no push that cycle. `fifo_count` drops to 3, then the push proceeds.
- Pointer wrap-around:
  - Stimulus: 3×DEPTH commands of SUB with a=i, b=1.
  - Response: results i−1 in order, including a=0 giving 255.
- Reset mid-stream:
  - Stimulus: assert `rst` with 3 queued and `rsp_valid`=1.
  - Response: next cycle `rsp_valid`=0, `fifo_count`=0, `alu_*`=0. No stale result emerges afterwards.
- Zero flag (macro defined):
  - Stimulus: XOR with a=b=0xA5.
  - Response: `rsp_zero`=1.
  - Stimulus: ADD with 1+1.
  - Response: `rsp_zero`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command-issue stage: opcodes, the command
// record and the issue FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SHL   = 3'd5;
    localparam logic [2:0] ALU_SHR   = 3'd6;
    localparam logic [2:0] ALU_PASSA = 3'd7;

    typedef struct packed {
        logic [2:0]           sel;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with occupancy count; full/empty are derived from the count.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of the combinational ALU: buffers commands,
// drives the FIFO head to the ALU and registers its result. Optional macro:
// ALU_CMD_ISSUE_ZERO_FLAG_EN adds a registered rsp_zero output.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_sel,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    output logic [2:0]             alu_sel,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [2:0]             rsp_sel,
`ifdef ALU_CMD_ISSUE_ZERO_FLAG_EN
    output logic                   rsp_zero,
`endif
    output logic [$clog2(DEPTH):0] fifo_count,
    output alu_state_e             state
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t wr_cmd;
    cmd_t head;
    logic full;
    logic empty;
    logic push;
    logic capture;
    logic has_head_next;
    logic rsp_next;

    // Both ports transfer on a rising edge where valid && ready; ready never
    // depends combinationally on the same-cycle pop, so a full FIFO refuses.
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign capture   = !empty && (!rsp_valid || rsp_ready);
    assign wr_cmd    = '{sel: cmd_sel, a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_cmd),
        .pop   (capture),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign alu_sel = empty ? 3'd0 : head.sel;
    assign alu_a   = empty ? '0 : head.a;
    assign alu_b   = empty ? '0 : head.b;

    assign has_head_next = push || (fifo_count > CW'(1)) || (!empty && !capture);
    assign rsp_next      = capture || (rsp_valid && !rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_sel    <= 3'd0;
`ifdef ALU_CMD_ISSUE_ZERO_FLAG_EN
            rsp_zero   <= 1'b0;
`endif
        end else begin
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_sel    <= head.sel;
`ifdef ALU_CMD_ISSUE_ZERO_FLAG_EN
                rsp_zero   <= (alu_result == '0);
`endif
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // STALL marks a held response blocking a waiting head command.
            if (!has_head_next && !rsp_next) begin
                state <= IDLE;
            end else if (rsp_valid && !rsp_ready && has_head_next) begin
                state <= STALL;
            end else begin
                state <= EXEC;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue with a behavioural ALU and an
// in-order scoreboard of {sel, result}.
module tb_alu_cmd_issue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_sel = 3'd0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_sel;
`ifdef ALU_CMD_ISSUE_ZERO_FLAG_EN
    logic             rsp_zero;
`endif
    logic [$clog2(DEPTH):0] fifo_count;
    alu_state_e       state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [10:0] exp_q[$];

    alu_cmd_issue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_sel    (rsp_sel),
`ifdef ALU_CMD_ISSUE_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .fifo_count (fifo_count),
        .state      (state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] alu_fn(input logic [2:0] s, input logic [7:0] a,
                                          input logic [7:0] b);
        case (s)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SHL: return a << 1;
            ALU_SHR: return a >> 1;
            default: return a;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_sel, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: transfers are sampled at negedge, committed at the next posedge
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e[7:0]));
                    check("rsp_sel", 32'(rsp_sel), 32'(e[10:8]));
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({cmd_sel, alu_fn(cmd_sel, cmd_a, cmd_b)});
            end
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1 after acceptance
    task automatic push_cmd(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || rsp_valid || fifo_count != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(n < 60), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_sel", 32'(rsp_sel), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // back-to-back a=15 b=3 sel=0..7, one result per cycle
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_sel = 3'(i);
            cmd_a   = 8'd15;
            cmd_b   = 8'd3;
            @(negedge clk);
            check("t1_cmd_ready", 32'(cmd_ready), 32'd1);
            check("t1_rsp_valid", 32'(rsp_valid), 32'(i >= 2));
            check("t1_fifo_count", 32'(fifo_count), 32'(i >= 1));
            if (i == 1) check("t1_state", 32'(state), 32'(EXEC));
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_rsp_valid_tail", 32'(rsp_valid), 32'd1);
        drain();
        check("t1_idle", 32'(state), 32'(IDLE));

        // backpressure: 5 pushes, 4 buffered plus 1 held response
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(ALU_ADD, 8'(10 + i), 8'(i));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_cmd_ready", 32'(cmd_ready), 32'd0);
            check("t2_fifo_count", 32'(fifo_count), 32'd4);
            check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
            check("t2_rsp_hold", 32'(rsp_result), 32'd10);
            check("t2_sel_hold", 32'(rsp_sel), 32'(ALU_ADD));
            check("t2_state", 32'(state), 32'(STALL));
            @(posedge clk);
            #1;
        end

        // simultaneous push/pop at full: pop first, push next cycle
        cmd_valid = 1'b1;
        cmd_sel   = ALU_XOR;
        cmd_a     = 8'h3c;
        cmd_b     = 8'h0f;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_full", 32'(cmd_ready), 32'd0);
        check("t3_count_full", 32'(fifo_count), 32'd4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_count_after_pop", 32'(fifo_count), 32'd3);
        check("t3_ready_after_pop", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t3_count_push_pop", 32'(fifo_count), 32'd3);
        drain();

        // pointer wrap: 3*DEPTH SUBs a=i b=1
        rsp_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) push_cmd(ALU_SUB, 8'(i), 8'd1);
        drain();

        // random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_sel   = 3'($urandom_range(0, 7));
            cmd_a     = 8'($urandom_range(0, 255));
            cmd_b     = 8'($urandom_range(0, 255));
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        drain();

        // reset mid-stream: 3 queued plus a pending response
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(ALU_OR, 8'(i), 8'h80);
        @(negedge clk);
        check("t5_count_pre", 32'(fifo_count), 32'd3);
        check("t5_rsp_valid_pre", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_fifo_count", 32'(fifo_count), 32'd0);
        check("t5_alu_zero", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        check("t5_state", 32'(state), 32'(IDLE));
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t5_no_stale", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

`ifdef ALU_CMD_ISSUE_ZERO_FLAG_EN
        rsp_ready = 1'b0;
        push_cmd(ALU_XOR, 8'ha5, 8'ha5);
        @(posedge clk);
        @(negedge clk);
        check("zf_valid_xor", 32'(rsp_valid), 32'd1);
        check("zf_xor", 32'(rsp_zero), 32'd1);
        drain();
        rsp_ready = 1'b0;
        push_cmd(ALU_ADD, 8'd1, 8'd1);
        @(posedge clk);
        @(negedge clk);
        check("zf_valid_add", 32'(rsp_valid), 32'd1);
        check("zf_add", 32'(rsp_zero), 32'd0);
        drain();
`endif

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
